// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
//   Execute stage of the 5-stage MIPS pipeline. Selects ALU operands using the
//   forwarding unit's ForwardA/ForwardB selects, performs the ALU operation and
//   registers result plus control into the EX/MEM pipeline register. MUL runs
//   on an iterative radix-2 shift-add multiplier that stalls the front of the
//   pipe while it works.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   Valid_EX, Flush_EX          EX holds a real instruction / kill it
//   ForwardA, ForwardB          operand select: 1 = MEM, 2 = WB, else regfile
//   Rs_data_EX, Rt_data_EX      register-file operands
//   Imm_EX, ALUSrc_EX           sign-extended immediate and operand-B select
//   ALUOp_EX                    ALU operation code
//   Rd_EX, *_EX control bits    destination register and control
//   Write_Data_WB               WB-stage result (Forward = 2 source)
//   ALU_Result_MEM              EX/MEM result (also the Forward = 1 source)
//   Store_Data_MEM              forwarded Rt value for stores
//   Rd_MEM, *_MEM control bits  registered destination and control
//   Stall_EX                    hold PC, IF/ID and ID/EX this cycle
// ----------------------------------------------------------------------------
module ex_stage #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Valid_EX,
    input  logic             Flush_EX,
    input  logic [1:0]       ForwardA,
    input  logic [1:0]       ForwardB,
    input  logic [WIDTH-1:0] Rs_data_EX,
    input  logic [WIDTH-1:0] Rt_data_EX,
    input  logic [WIDTH-1:0] Imm_EX,
    input  logic             ALUSrc_EX,
    input  logic [3:0]       ALUOp_EX,
    input  logic [4:0]       Rd_EX,
    input  logic             Reg_Write_EX,
    input  logic             Mem_Read_EX,
    input  logic             Mem_Write_EX,
    input  logic             Mem_to_Reg_EX,
    input  logic [WIDTH-1:0] Write_Data_WB,
    output logic [WIDTH-1:0] ALU_Result_MEM,
    output logic [WIDTH-1:0] Store_Data_MEM,
    output logic [4:0]       Rd_MEM,
    output logic             Reg_Write_MEM,
    output logic             Mem_Read_MEM,
    output logic             Mem_Write_MEM,
    output logic             Mem_to_Reg_MEM,
    output logic             Stall_EX
);

    localparam int            CW       = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [3:0]    OP_MUL   = 4'd12;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] ex_res;
    logic [4:0]       shamt;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mul_a;    // multiplicand, shifted left each step
    logic [WIDTH-1:0] mul_b;    // multiplier, shifted right each step
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_prod;

    logic mul_start;
    logic mul_run;
    logic mul_done;
    logic capture;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    always_comb begin
        case (ForwardA)
            2'd1:    fwd_a = ALU_Result_MEM;
            2'd2:    fwd_a = Write_Data_WB;
            default: fwd_a = Rs_data_EX;
        endcase
        case (ForwardB)
            2'd1:    fwd_b = ALU_Result_MEM;
            2'd2:    fwd_b = Write_Data_WB;
            default: fwd_b = Rt_data_EX;
        endcase
    end

    assign op_b  = ALUSrc_EX ? Imm_EX : fwd_b;
    assign shamt = fwd_a[4:0];

    // ------------------------------------------------------------------
    // Single-cycle ALU (MUL result comes from the iterative unit)
    // ------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        case (ALUOp_EX)
            4'd0:  alu_res = fwd_a + op_b;
            4'd1:  alu_res = fwd_a - op_b;
            4'd2:  alu_res = fwd_a & op_b;
            4'd3:  alu_res = fwd_a | op_b;
            4'd4:  alu_res = fwd_a ^ op_b;
            4'd5:  alu_res = ~(fwd_a | op_b);
            4'd6:  alu_res[0] = $signed(fwd_a) < $signed(op_b);
            4'd7:  alu_res[0] = fwd_a < op_b;
            4'd8:  alu_res = op_b << shamt;
            4'd9:  alu_res = op_b >> shamt;
            4'd10: alu_res = $unsigned($signed(op_b) >>> shamt);
            4'd11: alu_res = op_b << 16;
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiplier control
    // ------------------------------------------------------------------
    assign mul_start = (state == IDLE) & Valid_EX & (ALUOp_EX == OP_MUL) & ~Flush_EX;
    assign mul_run   = (state == BUSY) & (cnt != CNT_LAST);
    assign mul_done  = (state == BUSY) & (cnt == CNT_LAST);

    // The last multiplier bit is folded in combinationally so the product is
    // complete in the cycle the stall drops, without an extra BUSY cycle.
    assign mul_prod = mul_acc + (mul_b[0] ? mul_a : '0);

    // Gated by rst_n so the stall is also low while reset is held.
    assign Stall_EX = rst_n & ~Flush_EX & (mul_start | mul_run);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
        end else if (Flush_EX) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        state   <= BUSY;
                        cnt     <= '0;
                        mul_a   <= fwd_a;
                        mul_b   <= op_b;
                        mul_acc <= '0;
                    end
                end
                default: begin
                    if (mul_done) begin
                        state <= IDLE;
                    end else begin
                        mul_acc <= mul_prod;
                        mul_a   <= mul_a << 1;
                        mul_b   <= mul_b >> 1;
                        cnt     <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    assign capture = Valid_EX & ~Flush_EX & ~Stall_EX;
    assign ex_res  = mul_done ? mul_prod : alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_Result_MEM <= '0;
            Store_Data_MEM <= '0;
            Rd_MEM         <= '0;
            Reg_Write_MEM  <= 1'b0;
            Mem_Read_MEM   <= 1'b0;
            Mem_Write_MEM  <= 1'b0;
            Mem_to_Reg_MEM <= 1'b0;
        end else if (capture) begin
            ALU_Result_MEM <= ex_res;
            Store_Data_MEM <= fwd_b;
            Rd_MEM         <= Rd_EX;
            Reg_Write_MEM  <= Reg_Write_EX;
            Mem_Read_MEM   <= Mem_Read_EX;
            Mem_Write_MEM  <= Mem_Write_EX;
            Mem_to_Reg_MEM <= Mem_to_Reg_EX;
        end else begin
            // Bubble: control cleared, data fields keep their last value.
            Rd_MEM         <= '0;
            Reg_Write_MEM  <= 1'b0;
            Mem_Read_MEM   <= 1'b0;
            Mem_Write_MEM  <= 1'b0;
            Mem_to_Reg_MEM <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    localparam int W  = 32;
    localparam int MC = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         Valid_EX, Flush_EX;
    logic [1:0]   ForwardA, ForwardB;
    logic [W-1:0] Rs_data_EX, Rt_data_EX, Imm_EX;
    logic         ALUSrc_EX;
    logic [3:0]   ALUOp_EX;
    logic [4:0]   Rd_EX;
    logic         Reg_Write_EX, Mem_Read_EX, Mem_Write_EX, Mem_to_Reg_EX;
    logic [W-1:0] Write_Data_WB;
    logic [W-1:0] ALU_Result_MEM, Store_Data_MEM;
    logic [4:0]   Rd_MEM;
    logic         Reg_Write_MEM, Mem_Read_MEM, Mem_Write_MEM, Mem_to_Reg_MEM;
    logic         Stall_EX;

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n), .Valid_EX(Valid_EX), .Flush_EX(Flush_EX),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .Rs_data_EX(Rs_data_EX), .Rt_data_EX(Rt_data_EX), .Imm_EX(Imm_EX),
        .ALUSrc_EX(ALUSrc_EX), .ALUOp_EX(ALUOp_EX), .Rd_EX(Rd_EX),
        .Reg_Write_EX(Reg_Write_EX), .Mem_Read_EX(Mem_Read_EX),
        .Mem_Write_EX(Mem_Write_EX), .Mem_to_Reg_EX(Mem_to_Reg_EX),
        .Write_Data_WB(Write_Data_WB),
        .ALU_Result_MEM(ALU_Result_MEM), .Store_Data_MEM(Store_Data_MEM),
        .Rd_MEM(Rd_MEM), .Reg_Write_MEM(Reg_Write_MEM), .Mem_Read_MEM(Mem_Read_MEM),
        .Mem_Write_MEM(Mem_Write_MEM), .Mem_to_Reg_MEM(Mem_to_Reg_MEM),
        .Stall_EX(Stall_EX)
    );

    int checks = 0;
    int errors = 0;

    // Model of the EX/MEM data fields (what the pipeline should hold)
    logic [W-1:0] m_res;
    logic [W-1:0] m_store;

    logic [3:0] ctl_mem;
    assign ctl_mem = {Reg_Write_MEM, Mem_Read_MEM, Mem_Write_MEM, Mem_to_Reg_MEM};

    // Reference ALU computed with plain wide arithmetic
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                             input logic [W-1:0] a, b);
        longint sb;
        logic [63:0] p;
        sb = longint'($signed(b));
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << a[4:0];
            4'd9:  return b >> a[4:0];
            4'd10: return W'(sb >>> a[4:0]);
            4'd11: return W'(64'(b) * 64'd65536);
            4'd12: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] pick(input logic [1:0] s,
                                          input logic [W-1:0] rf, mem, wb);
        if (s == 2'd1) return mem;
        if (s == 2'd2) return wb;
        return rf;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [W-1:0] rs, rt, imm,
                             input logic src, input logic [1:0] fa, fb,
                             input logic [4:0] rd, input logic [3:0] ctl);
        Valid_EX   = 1'b1;
        Flush_EX   = 1'b0;
        ALUOp_EX   = op;
        Rs_data_EX = rs;
        Rt_data_EX = rt;
        Imm_EX     = imm;
        ALUSrc_EX  = src;
        ForwardA   = fa;
        ForwardB   = fb;
        Rd_EX      = rd;
        {Reg_Write_EX, Mem_Read_EX, Mem_Write_EX, Mem_to_Reg_EX} = ctl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        Valid_EX = 1'b0; Flush_EX = 1'b0; ForwardA = '0; ForwardB = '0;
        Rs_data_EX = '0; Rt_data_EX = '0; Imm_EX = '0; ALUSrc_EX = 1'b0;
        ALUOp_EX = '0; Rd_EX = '0; Write_Data_WB = '0;
        {Reg_Write_EX, Mem_Read_EX, Mem_Write_EX, Mem_to_Reg_EX} = 4'b0;
        #12;
        checks++;
        if (ALU_Result_MEM !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", ALU_Result_MEM); end
        checks++;
        if (Store_Data_MEM !== '0) begin errors++; $display("FAIL reset_store: got %h expected 0", Store_Data_MEM); end
        checks++;
        if ({ctl_mem, Rd_MEM} !== 9'd0) begin errors++; $display("FAIL reset_ctl_rd: got %h expected 0", {ctl_mem, Rd_MEM}); end
        checks++;
        if (Stall_EX !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", Stall_EX); end
        m_res = '0;
        m_store = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_forward();
        set_instr(4'd0, 32'h10, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0, 5'd3, 4'b1000);
        step();
        checks++;
        if (ALU_Result_MEM !== 32'h10) begin errors++; $display("FAIL add_setup: got %h expected 00000010", ALU_Result_MEM); end
        m_res = 32'h10;
        set_instr(4'd0, 32'h1234, 32'h5678, 32'h0, 1'b0, 2'd1, 2'd2, 5'd9, 4'b1000);
        Write_Data_WB = 32'h5;
        step();
        checks++;
        if (ALU_Result_MEM !== 32'h15) begin errors++; $display("FAIL add_fwd_result: got %h expected 00000015", ALU_Result_MEM); end
        checks++;
        if (Rd_MEM !== 5'd9 || ctl_mem !== 4'b1000) begin errors++; $display("FAIL add_fwd_rd_ctl: got %h/%b expected 09/1000", Rd_MEM, ctl_mem); end
        checks++;
        if (Store_Data_MEM !== 32'h5) begin errors++; $display("FAIL add_fwd_store: got %h expected 00000005", Store_Data_MEM); end
        m_res = 32'h15;
        m_store = 32'h5;
    endtask

    task automatic test_store();
        set_instr(4'd0, 32'h1000, 32'hDEAD, 32'h8, 1'b1, 2'd0, 2'd1, 5'd0, 4'b0010);
        step();
        checks++;
        if (ALU_Result_MEM !== 32'h1008) begin errors++; $display("FAIL sw_addr: got %h expected 00001008", ALU_Result_MEM); end
        checks++;
        if (Store_Data_MEM !== 32'h15) begin errors++; $display("FAIL sw_store_data: got %h expected 00000015", Store_Data_MEM); end
        checks++;
        if (ctl_mem !== 4'b0010) begin errors++; $display("FAIL sw_ctl: got %b expected 0010", ctl_mem); end
        m_res = 32'h1008;
        m_store = 32'h15;
    endtask

    task automatic test_directed_alu();
        set_instr(4'd10, 32'd4, 32'h80000000, 32'h0, 1'b0, 2'd0, 2'd0, 5'd1, 4'b1000);
        step();
        checks++;
        if (ALU_Result_MEM !== 32'hF8000000) begin errors++; $display("FAIL sra: got %h expected f8000000", ALU_Result_MEM); end
        set_instr(4'd6, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 2'd0, 2'd0, 5'd2, 4'b1000);
        step();
        checks++;
        if (ALU_Result_MEM !== 32'h1) begin errors++; $display("FAIL slt: got %h expected 00000001", ALU_Result_MEM); end
        set_instr(4'd7, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 2'd0, 2'd0, 5'd2, 4'b1000);
        step();
        checks++;
        if (ALU_Result_MEM !== 32'h0) begin errors++; $display("FAIL sltu: got %h expected 00000000", ALU_Result_MEM); end
        set_instr(4'd11, 32'h0, 32'h0, 32'h0000ABCD, 1'b1, 2'd0, 2'd0, 5'd4, 4'b1000);
        step();
        checks++;
        if (ALU_Result_MEM !== 32'hABCD0000) begin errors++; $display("FAIL lui: got %h expected abcd0000", ALU_Result_MEM); end
        m_res = 32'hABCD0000;
        m_store = 32'h0;
    endtask

    task automatic test_random_alu();
        logic [3:0] op;
        logic [1:0] fa, fb;
        logic [W-1:0] rs, rt, imm, a, b, ob, exp;
        logic src, valid, flush, cap;
        logic [4:0] rd;
        logic [3:0] ctl;
        logic prev_bubble;
        prev_bubble = 1'b0;
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd12) op = 4'd0;
            fa = 2'($urandom_range(0, 3));
            fb = 2'($urandom_range(0, 3));
            if (prev_bubble && fa == 2'd1) fa = 2'd0;
            if (prev_bubble && fb == 2'd1) fb = 2'd0;
            rs = $urandom; rt = $urandom; imm = $urandom;
            src = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 31));
            ctl = 4'($urandom_range(0, 15));
            valid = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 9) == 0);
            set_instr(op, rs, rt, imm, src, fa, fb, rd, ctl);
            Valid_EX = valid;
            Flush_EX = flush;
            Write_Data_WB = $urandom;
            a = pick(fa, rs, m_res, Write_Data_WB);
            b = pick(fb, rt, m_res, Write_Data_WB);
            ob = src ? imm : b;
            exp = ref_alu(op, a, ob);
            cap = valid && !flush;
            #1;
            checks++;
            if (Stall_EX !== 1'b0) begin errors++; $display("FAIL rand_stall[%0d]: got %b expected 0", n, Stall_EX); end
            step();
            if (cap) begin
                checks++;
                if (ALU_Result_MEM !== exp) begin errors++; $display("FAIL rand_result[%0d] op %0d: got %h expected %h", n, op, ALU_Result_MEM, exp); end
                checks++;
                if (Store_Data_MEM !== b) begin errors++; $display("FAIL rand_store[%0d]: got %h expected %h", n, Store_Data_MEM, b); end
                checks++;
                if ({ctl_mem, Rd_MEM} !== {ctl, rd}) begin errors++; $display("FAIL rand_ctl_rd[%0d]: got %h expected %h", n, {ctl_mem, Rd_MEM}, {ctl, rd}); end
                m_res = exp;
                m_store = b;
            end else begin
                checks++;
                if ({ctl_mem, Rd_MEM} !== 9'd0) begin errors++; $display("FAIL rand_bubble[%0d]: got %h expected 0", n, {ctl_mem, Rd_MEM}); end
            end
            prev_bubble = !cap;
        end
    endtask

    // Operand A comes from WB, which is scrambled during the stall.
    task automatic run_mul(input logic [W-1:0] a, b, input logic [4:0] rd);
        logic [W-1:0] exp;
        exp = ref_alu(4'd12, a, b);
        set_instr(4'd12, $urandom, b, $urandom, 1'b0, 2'd2, 2'd0, rd, 4'b1000);
        Write_Data_WB = a;
        for (int i = 0; i < MC; i++) begin
            #1;
            checks++;
            if (Stall_EX !== 1'b1) begin errors++; $display("FAIL mul_stall cycle %0d: got %b expected 1", i, Stall_EX); end
            step();
            checks++;
            if ({ctl_mem, Rd_MEM} !== 9'd0 || ALU_Result_MEM !== m_res) begin
                errors++;
                $display("FAIL mul_bubble cycle %0d: got %h/%h expected 0/%h", i, {ctl_mem, Rd_MEM}, ALU_Result_MEM, m_res);
            end
            Write_Data_WB = $urandom;
        end
        #1;
        checks++;
        if (Stall_EX !== 1'b0) begin errors++; $display("FAIL mul_stall_release: got %b expected 0", Stall_EX); end
        step();
        checks++;
        if (ALU_Result_MEM !== exp) begin errors++; $display("FAIL mul_result %h*%h: got %h expected %h", a, b, ALU_Result_MEM, exp); end
        checks++;
        if ({ctl_mem, Rd_MEM} !== {4'b1000, rd} || Store_Data_MEM !== b) begin
            errors++;
            $display("FAIL mul_ctl_store: got %h/%h expected %h/%h", {ctl_mem, Rd_MEM}, Store_Data_MEM, {4'b1000, rd}, b);
        end
        m_res = exp;
        m_store = b;
    endtask

    task automatic test_mul();
        run_mul(32'd7, 32'hFFFFFFFD, 5'd5);
        checks++;
        if (ALU_Result_MEM !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_directed: got %h expected ffffffeb", ALU_Result_MEM); end
        Valid_EX = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            run_mul($urandom, $urandom, 5'($urandom_range(1, 31)));
            Valid_EX = 1'b0;
            step();
        end
    endtask

    task automatic test_back_to_back();
        run_mul($urandom, $urandom, 5'd6);
        run_mul($urandom, $urandom, 5'd7);
        Valid_EX = 1'b0;
        step();
    endtask

    task automatic test_mul_flush();
        set_instr(4'd12, 32'd3, 32'd9, 32'h0, 1'b0, 2'd0, 2'd0, 5'd10, 4'b1000);
        for (int k = 0; k < 11; k++) step();
        Flush_EX = 1'b1;
        #1;
        checks++;
        if (Stall_EX !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", Stall_EX); end
        step();
        checks++;
        if ({ctl_mem, Rd_MEM} !== 9'd0) begin errors++; $display("FAIL flush_bubble: got %h expected 0", {ctl_mem, Rd_MEM}); end
        set_instr(4'd0, 32'h100, 32'h23, 32'h0, 1'b0, 2'd0, 2'd0, 5'd11, 4'b1000);
        #1;
        checks++;
        if (Stall_EX !== 1'b0) begin errors++; $display("FAIL flush_add_stall: got %b expected 0", Stall_EX); end
        step();
        checks++;
        if (ALU_Result_MEM !== 32'h123 || Rd_MEM !== 5'd11 || ctl_mem !== 4'b1000) begin
            errors++;
            $display("FAIL flush_add: got %h/%h/%b expected 00000123/0b/1000", ALU_Result_MEM, Rd_MEM, ctl_mem);
        end
        m_res = 32'h123;
        m_store = 32'h23;
        run_mul($urandom, $urandom, 5'd12);
        Valid_EX = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_mul();
        set_instr(4'd0, 32'h55, 32'h66, 32'h0, 1'b0, 2'd0, 2'd0, 5'd13, 4'b1111);
        step();
        set_instr(4'd12, 32'd5, 32'd6, 32'h0, 1'b0, 2'd0, 2'd0, 5'd14, 4'b1000);
        for (int k = 0; k < 6; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ALU_Result_MEM !== '0 || Store_Data_MEM !== '0) begin
            errors++;
            $display("FAIL rst_mid_data: got %h/%h expected 0/0", ALU_Result_MEM, Store_Data_MEM);
        end
        checks++;
        if ({ctl_mem, Rd_MEM} !== 9'd0) begin errors++; $display("FAIL rst_mid_ctl: got %h expected 0", {ctl_mem, Rd_MEM}); end
        checks++;
        if (Stall_EX !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0", Stall_EX); end
        Valid_EX = 1'b0;
        m_res = '0;
        m_store = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_mul($urandom, $urandom, 5'd15);
        Valid_EX = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_add_forward();
        test_store();
        test_directed_alu();
        test_random_alu();
        test_mul();
        test_back_to_back();
        test_mul_flush();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes ForwardA/ForwardB from the forwarding unit to select ALU operands, performs the ALU operation, and registers the result and control into the EX/MEM pipeline register.
- Its registered Rd_MEM/Reg_Write_MEM outputs feed back into the forwarding unit.
- Contains an iterative shift-add multiplier that stalls the front of the pipe while busy.

Parameters:
- WIDTH, 32, datapath width.
- MUL_CYCLES, 32, stall cycles for a MUL; must equal WIDTH for the radix-2 multiplier.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- Valid_EX  in  1  EX holds a real instruction (0 = bubble)
- Flush_EX  in  1  kill the EX instruction this cycle
- ForwardA, ForwardB  in  2  operand select: 0 = register file, 1 = MEM, 2 = WB, 3 = register file
- Rs_data_EX, Rt_data_EX  in  WIDTH  register-file operands
- Imm_EX  in  WIDTH  sign-extended immediate
- ALUSrc_EX  in  1  1 = operand B is Imm_EX
- ALUOp_EX  in  4  operation code, see Behaviour
- Rd_EX  in  5  destination register
- Reg_Write_EX, Mem_Read_EX, Mem_Write_EX, Mem_to_Reg_EX  in  1 each  control
- Write_Data_WB  in  WIDTH  WB-stage result, used for Forward=2
- ALU_Result_MEM  out  WIDTH  EX/MEM result; also the Forward=1 source
- Store_Data_MEM  out  WIDTH  forwarded Rt value for stores
- Rd_MEM  out  5
- Reg_Write_MEM, Mem_Read_MEM, Mem_Write_MEM, Mem_to_Reg_MEM  out  1 each
- Stall_EX  out  1  hold PC, IF/ID and ID/EX this cycle

Behaviour:
- Reset (async, rst_n=0):
  - All EX/MEM outputs go to 0; Rd_MEM=0.
  - Multiplier goes idle, counter=0, Stall_EX=0.
- Operand selection (combinational):
  - fwdA = ForwardA==1 ? ALU_Result_MEM : ForwardA==2 ? Write_Data_WB : Rs_data_EX. fwdB is selected the same way from Rt_data_EX.
  - opB = ALUSrc_EX ? Imm_EX : fwdB.
  - Store_Data source is always fwdB, never Imm_EX.
- ALU ops (result truncated to WIDTH):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed; result is 1 or 0.
  - 7 SLTU: unsigned; result is 1 or 0.
  - 8 SLL: opB << fwdA[4:0].
  - 9 SRL: logical right shift, same operands as SLL.
  - 10 SRA: arithmetic right shift, same operands as SLL.
  - 11 LUI: opB << 16.
  - 12 MUL: low WIDTH bits of fwdA*opB (two's-complement low half).
  - 13–15 yield 0.
  - No overflow traps.
- Single-cycle ops: at each rising edge with Stall_EX=0, the EX/MEM register captures the result, fwdB, Rd_EX and control.
- MUL state machine, states IDLE and BUSY:
  - IDLE→BUSY when Valid_EX & ALUOp==12 & ~Flush_EX. In that cycle (cycle 0), fwdA and opB are latched and counter is cleared.
  - Stall_EX = 1 in cycle 0 and in every BUSY cycle while counter < MUL_CYCLES-1. It is combinational in cycle 0.
  - In BUSY, one multiplier bit is processed per cycle and the counter increments.
  - In cycle MUL_CYCLES: state is BUSY with the counter at its last value, Stall_EX=0, and the product is presented. The EX/MEM register captures it with control, then the FSM returns to IDLE.
  - Total EX occupancy is MUL_CYCLES+1 cycles.
  - While stalled, EX/MEM captures a bubble: all control bits 0, Rd_MEM=0, data don't-care but held.
  - Latched operands make the result immune to MEM/WB advancing during the stall.
- Flush_EX, highest priority:
  - EX/MEM captures a bubble.
  - A BUSY multiplier aborts to IDLE and Stall_EX drops in the same cycle.
- Bubble handling: Valid_EX=0 writes a bubble and never starts a MUL.
- Rd_EX=0: fields pass through unchanged. Filtering of register 0 is the forwarding unit's job.
- Back-to-back MULs: the second MUL starts in the cycle after the first completes. There is no idle gap.

Test Plan:
- ADD, ForwardA=1 with ALU_Result_MEM=0x10, ForwardB=2 with Write_Data_WB=0x5 -> next cycle ALU_Result_MEM=0x15, Rd_MEM=Rd_EX.
- SW with ALUSrc=1, Imm=8, ForwardB=1 -> ALU_Result_MEM=base+8 and Store_Data_MEM equals the forwarded MEM value, not Imm.
- MUL 7 * 0xFFFFFFFD -> Stall_EX high for 32 cycles with bubbles in EX/MEM, then ALU_Result_MEM=0xFFFFFFEB with Reg_Write_MEM=1. Changing Write_Data_WB during the stall has no effect.
- MUL with Flush_EX pulsed at BUSY cycle 10 -> Stall_EX low that cycle, bubble in EX/MEM, FSM back in IDLE, and the next ADD completes in 1 cycle.
- rst_n low at BUSY cycle 5 -> all outputs 0 immediately (asynchronously), Stall_EX=0. After release, a fresh MUL takes the full 33 cycles.
- SRA 0x80000000 by 4 -> 0xF8000000. SLT with -1 vs 1 gives 1; SLTU with the same operands gives 0.
